// File: rtl/mem_access_unit.sv
// Multi-cycle big-endian load/store unit with sub-word extension and read-modify-write stores.
// Define MEM_BYTE_ENABLE_EN to add MemBe and write sub-words directly with lane enables.
module mem_access_unit #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  Start,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [1:0]            Size,
  input  logic                  LoadUnsigned,
  input  logic [ADDR_WIDTH-1:0] Addr,
  input  logic [31:0]           WriteData,
  output logic [31:0]           ReadData,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Error,
  output logic [ADDR_WIDTH-3:0] MemAddr,
  output logic                  MemRdEn,
  output logic                  MemWrEn,
  output logic [31:0]           MemWData,
`ifdef MEM_BYTE_ENABLE_EN
  output logic [3:0]            MemBe,
`endif
  input  logic [31:0]           MemRData
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_READ    = 3'd1,
    S_CAPTURE = 3'd2,
    S_WRITE   = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  // Big-endian lane select: offset 0 is the most significant byte/half.
  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] off, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = 8'(word >> {2'd3 - off, 3'b000});
    h = off[1] ? word[15:0] : word[31:16];
    case (size)
      SZ_BYTE: r = uns ? {24'h000000, b} : {{24{b[7]}}, b};
      SZ_HALF: r = uns ? {16'h0000, h} : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [31:0] data,
                                              input logic [1:0] size, input logic [1:0] off);
    logic [4:0]  sh;
    logic [31:0] mask;
    case (size)
      SZ_BYTE: begin sh = {2'd3 - off, 3'b000};   mask = 32'h0000_00FF << sh; end
      SZ_HALF: begin sh = off[1] ? 5'd0 : 5'd16; mask = 32'h0000_FFFF << sh; end
      default: begin sh = 5'd0;                   mask = 32'hFFFF_FFFF;       end
    endcase
    return (word & ~mask) | ((data << sh) & mask);
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = off[0];
      SZ_WORD: misaligned = (off != 2'b00);
      default: misaligned = 1'b1;
    endcase
  endfunction

`ifdef MEM_BYTE_ENABLE_EN
  function automatic logic [3:0] lane_enables(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: lane_enables = 4'b1000 >> off;
      SZ_HALF: lane_enables = off[1] ? 4'b0011 : 4'b1100;
      default: lane_enables = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] replicate(input logic [31:0] data, input logic [1:0] size);
    case (size)
      SZ_BYTE: replicate = {4{data[7:0]}};
      SZ_HALF: replicate = {2{data[15:0]}};
      default: replicate = data;
    endcase
  endfunction

  logic [3:0] be_q;
  assign MemBe = be_q;
`endif

  state_t                state_q;
  logic [31:0]           read_data_q, mem_wdata_q, wdata_q;
  logic [ADDR_WIDTH-3:0] mem_addr_q;
  logic [1:0]            size_q, off_q;
  logic                  uns_q, store_q, busy_q, done_q, error_q, rd_en_q, wr_en_q;

  // Request sequencing FSM; every output is a register written here.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q     <= S_IDLE;
      read_data_q <= 32'h0000_0000;
      mem_wdata_q <= 32'h0000_0000;
      wdata_q     <= 32'h0000_0000;
      mem_addr_q  <= '0;
      size_q      <= 2'b00;
      off_q       <= 2'b00;
      uns_q       <= 1'b0;
      store_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      wr_en_q     <= 1'b0;
`ifdef MEM_BYTE_ENABLE_EN
      be_q        <= 4'b0000;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (Start) begin
            busy_q     <= 1'b1;
            mem_addr_q <= Addr[ADDR_WIDTH-1:2];
            size_q     <= Size;
            off_q      <= Addr[1:0];
            uns_q      <= LoadUnsigned;
            wdata_q    <= WriteData;
            store_q    <= MemWrite;
            if (!MemRead && !MemWrite) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else if ((MemRead && MemWrite) || misaligned(Size, Addr[1:0])) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              error_q <= 1'b1;
            end else if (MemRead || (Size != SZ_WORD)) begin
`ifdef MEM_BYTE_ENABLE_EN
              if (MemWrite) begin
                state_q     <= S_WRITE;
                wr_en_q     <= 1'b1;
                mem_wdata_q <= replicate(WriteData, Size);
                be_q        <= lane_enables(Size, Addr[1:0]);
              end else begin
                state_q <= S_READ;
                rd_en_q <= 1'b1;
              end
`else
              state_q <= S_READ;
              rd_en_q <= 1'b1;
`endif
            end else begin
              state_q     <= S_WRITE;
              wr_en_q     <= 1'b1;
              mem_wdata_q <= WriteData;
`ifdef MEM_BYTE_ENABLE_EN
              be_q        <= 4'b1111;
`endif
            end
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_READ: begin
          rd_en_q <= 1'b0;
          state_q <= S_CAPTURE;
        end
        S_CAPTURE: begin
          if (store_q) begin
            mem_wdata_q <= store_merge(MemRData, wdata_q, size_q, off_q);
            wr_en_q     <= 1'b1;
            state_q     <= S_WRITE;
          end else begin
            read_data_q <= load_extend(MemRData, size_q, off_q, uns_q);
            done_q      <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_WRITE: begin
          wr_en_q <= 1'b0;
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end
        S_DONE: begin
          done_q  <= 1'b0;
          error_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          rd_en_q <= 1'b0;
          wr_en_q <= 1'b0;
          done_q  <= 1'b0;
          error_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ReadData = read_data_q;
  assign Busy     = busy_q;
  assign Done     = done_q;
  assign Error    = error_q;
  assign MemAddr  = mem_addr_q;
  assign MemRdEn  = rd_en_q;
  assign MemWrEn  = wr_en_q;
  assign MemWData = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: driver queues expected completions, monitor checks each Done.
module tb_mem_access_unit;

  localparam logic [1:0] B = 2'b00;
  localparam logic [1:0] H = 2'b01;
  localparam logic [1:0] W = 2'b11;
`ifdef MEM_BYTE_ENABLE_EN
  localparam int SUB_LAT = 2;
  localparam int SUB_RD  = 0;
`else
  localparam int SUB_LAT = 4;
  localparam int SUB_RD  = 1;
`endif

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        Start = 1'b0, MemRead = 1'b0, MemWrite = 1'b0, LoadUnsigned = 1'b0;
  logic [1:0]  Size = 2'b00;
  logic [31:0] Addr = 32'h0, WriteData = 32'h0;
  logic [31:0] ReadData, MemWData;
  logic [31:0] MemRData = 32'h0;
  logic        Busy, Done, Error, MemRdEn, MemWrEn;
  logic [29:0] MemAddr;
`ifdef MEM_BYTE_ENABLE_EN
  logic [3:0]  MemBe;
`endif

  mem_access_unit #(.ADDR_WIDTH(32)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .MemRead(MemRead), .MemWrite(MemWrite),
    .Size(Size), .LoadUnsigned(LoadUnsigned), .Addr(Addr), .WriteData(WriteData),
    .ReadData(ReadData), .Busy(Busy), .Done(Done), .Error(Error), .MemAddr(MemAddr),
    .MemRdEn(MemRdEn), .MemWrEn(MemWrEn), .MemWData(MemWData),
`ifdef MEM_BYTE_ENABLE_EN
    .MemBe(MemBe),
`endif
    .MemRData(MemRData)
  );

  always #5 Clk = ~Clk;

  typedef struct { logic err; logic [31:0] rdata; int cyc; } exp_t;
  exp_t exp_q[$];
  exp_t e;
  int checks = 0, errors = 0, cyc = 0, rd_cnt = 0, wr_cnt = 0;
  int rd0, wr0;
  logic [31:0] mem [0:63];

  always @(posedge Clk) cyc <= cyc + 1;

  // Synchronous word memory model with strobe counters.
  always @(posedge Clk) begin
    if (MemRdEn) begin
      MemRData <= mem[MemAddr[5:0]];
      rd_cnt   <= rd_cnt + 1;
    end
    if (MemWrEn) begin
      wr_cnt <= wr_cnt + 1;
`ifdef MEM_BYTE_ENABLE_EN
      for (int j = 0; j < 4; j++)
        if (MemBe[j]) mem[MemAddr[5:0]][8*j +: 8] <= MemWData[8*j +: 8];
`else
      mem[MemAddr[5:0]] <= MemWData;
`endif
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Monitor: every Done pops one expectation.
  always @(negedge Clk) begin
    if (Rst && Done) begin
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done at cycle %0d", cyc);
      end else begin
        e = exp_q.pop_front();
        chk("done_error", {31'b0, Error}, {31'b0, e.err});
        chk("read_data", ReadData, e.rdata);
        chk("done_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
    if (Rst && Error && !Done) begin
      errors++;
      $display("FAIL error_without_done at cycle %0d", cyc);
    end
  end

  task automatic issue(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd, input logic e_err,
                       input logic [31:0] e_rd, input int lat, input bit track);
    @(negedge Clk);
    MemRead = rd; MemWrite = wr; Size = sz; LoadUnsigned = uns; Addr = a; WriteData = wd;
    Start = 1'b1;
    if (track) exp_q.push_back('{err: e_err, rdata: e_rd, cyc: cyc + lat});
    @(posedge Clk); #1;
    Start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge Clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL done_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge Clk);
  endtask

  task automatic op(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                    input logic [31:0] a, input logic [31:0] wd, input logic e_err,
                    input logic [31:0] e_rd, input int lat);
    issue(rd, wr, sz, uns, a, wd, e_err, e_rd, lat, 1'b1);
    wait_done();
  endtask

  initial begin
    #1;
    chk("rst_read_data", ReadData, 32'h0);
    chk("rst_flags", {26'b0, Busy, Done, Error, MemRdEn, MemWrEn, 1'b0}, 32'h0);
    chk("rst_mem_addr", {2'b00, MemAddr}, 32'h0);
    chk("rst_mem_wdata", MemWData, 32'h0);
    repeat (2) @(negedge Clk);
    Rst = 1'b1;

    rd0 = rd_cnt; wr0 = wr_cnt;
    op(1'b0, 1'b1, W, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 2);
    chk("sw_mem", mem[4], 32'hDEADBEEF);
    chk("sw_strobes", 32'((rd_cnt - rd0) * 16 + (wr_cnt - wr0)), 32'h1);
    rd0 = rd_cnt; wr0 = wr_cnt;
    op(1'b1, 1'b0, W, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 3);
    chk("lw_strobes", 32'((rd_cnt - rd0) * 16 + (wr_cnt - wr0)), 32'h10);
    chk("lw_mem_addr", {2'b00, MemAddr}, 32'h4);

    op(1'b0, 1'b1, W, 1'b0, 32'h10, 32'h12F45678, 1'b0, 32'hDEADBEEF, 2);
    op(1'b1, 1'b0, B, 1'b0, 32'h11, 32'h0, 1'b0, 32'hFFFFFFF4, 3);
    op(1'b1, 1'b0, B, 1'b1, 32'h11, 32'h0, 1'b0, 32'h000000F4, 3);
    op(1'b1, 1'b0, B, 1'b0, 32'h13, 32'h0, 1'b0, 32'h00000078, 3);
    op(1'b1, 1'b0, H, 1'b0, 32'h12, 32'h0, 1'b0, 32'h00005678, 3);
    op(1'b1, 1'b0, H, 1'b1, 32'h10, 32'h0, 1'b0, 32'h000012F4, 3);

    op(1'b0, 1'b1, W, 1'b0, 32'h10, 32'h11223344, 1'b0, 32'h000012F4, 2);
    rd0 = rd_cnt; wr0 = wr_cnt;
    op(1'b0, 1'b1, B, 1'b0, 32'h13, 32'h000000AA, 1'b0, 32'h000012F4, SUB_LAT);
    chk("sb_mem", mem[4], 32'h112233AA);
    chk("sb_strobes", 32'((rd_cnt - rd0) * 16 + (wr_cnt - wr0)), 32'(SUB_RD * 16 + 1));

    op(1'b0, 1'b1, W, 1'b0, 32'h20, 32'h11223344, 1'b0, 32'h000012F4, 2);
    op(1'b0, 1'b1, H, 1'b0, 32'h22, 32'h0000BEEF, 1'b0, 32'h000012F4, SUB_LAT);
    chk("sh_lo_mem", mem[8], 32'h1122BEEF);
    op(1'b0, 1'b1, H, 1'b0, 32'h20, 32'hCAFE8001, 1'b0, 32'h000012F4, SUB_LAT);
    chk("sh_hi_mem", mem[8], 32'h8001BEEF);
    op(1'b1, 1'b0, H, 1'b0, 32'h20, 32'h0, 1'b0, 32'hFFFF8001, 3);
    op(1'b1, 1'b0, H, 1'b1, 32'h20, 32'h0, 1'b0, 32'h00008001, 3);
    op(1'b0, 1'b1, B, 1'b0, 32'h20, 32'h1234565A, 1'b0, 32'h00008001, SUB_LAT);
    chk("sb0_mem", mem[8], 32'h5A01BEEF);
    op(1'b1, 1'b0, B, 1'b0, 32'h21, 32'h0, 1'b0, 32'h00000001, 3);
    op(1'b1, 1'b0, B, 1'b0, 32'h20, 32'h0, 1'b0, 32'h0000005A, 3);

    // Rejections and no-op: single-cycle completion, no memory strobes.
    rd0 = rd_cnt; wr0 = wr_cnt;
    op(1'b1, 1'b0, H, 1'b0, 32'h21, 32'h0, 1'b1, 32'h0000005A, 1);
    op(1'b1, 1'b0, W, 1'b0, 32'h22, 32'h0, 1'b1, 32'h0000005A, 1);
    op(1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h0, 1'b1, 32'h0000005A, 1);
    op(1'b1, 1'b1, W, 1'b0, 32'h20, 32'h0, 1'b1, 32'h0000005A, 1);
    op(1'b0, 1'b0, W, 1'b0, 32'h20, 32'h0, 1'b0, 32'h0000005A, 1);
    chk("reject_strobes", 32'((rd_cnt - rd0) * 16 + (wr_cnt - wr0)), 32'h0);
    chk("reject_mem", mem[8], 32'h5A01BEEF);

    // Start while busy is dropped, not queued.
    rd0 = rd_cnt; wr0 = wr_cnt;
    issue(1'b0, 1'b1, B, 1'b0, 32'h13, 32'h00000055, 1'b0, 32'h0000005A, SUB_LAT, 1'b1);
    MemRead = 1'b1; MemWrite = 1'b0; Size = W; Addr = 32'h10; Start = 1'b1;
    repeat (2) @(posedge Clk);
    #1 Start = 1'b0;
    wait_done();
    repeat (4) @(negedge Clk);
    chk("busy_sb_mem", mem[4], 32'h11223355);
    chk("busy_sb_strobes", 32'((rd_cnt - rd0) * 16 + (wr_cnt - wr0)), 32'(SUB_RD * 16 + 1));

    // Reset dropped while a write is on the bus.
    op(1'b0, 1'b1, W, 1'b0, 32'h30, 32'h01020304, 1'b0, 32'h0000005A, 2);
    wr0 = wr_cnt;
    issue(1'b0, 1'b1, W, 1'b0, 32'h30, 32'hFFFFFFFF, 1'b0, 32'h0, 0, 1'b0);
    chk("write_active", {31'b0, MemWrEn}, 32'h1);
    #2 Rst = 1'b0;
    #1;
    chk("rst_mid_flags", {27'b0, Busy, Done, Error, MemRdEn, MemWrEn}, 32'h0);
    chk("rst_mid_read_data", ReadData, 32'h0);
    @(posedge Clk); @(negedge Clk);
    chk("rst_mid_mem", mem[12], 32'h01020304);
    chk("rst_mid_writes", 32'(wr_cnt - wr0), 32'h0);
    Rst = 1'b1;
    op(1'b1, 1'b0, W, 1'b0, 32'h30, 32'h0, 1'b0, 32'h01020304, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Multi-cycle load/store unit between the ALU result and a word-wide synchronous data memory. It executes the memory requests decoded by the datapath controller (LW/LH/LB, SW/SH/SB) and extracts and sign- or zero-extends loaded bytes and halfwords. Sub-word stores use read-modify-write. It raises `Busy` so the datapath can stall until `Done`.

## Interface
- `ADDR_WIDTH`, 32, byte-address width; memory word address is `ADDR_WIDTH-2` bits.
- `Clk`  in  1  sole clock; all state updates on rising edge.
- `Rst`  in  1  asynchronous, active-low reset.
- `Start`  in  1  request strobe; sampled only in IDLE.
- `MemRead`  in  1  load request (controller MemRead).
- `MemWrite`  in  1  store request (controller MemWrite).
- `Size`  in  2  OpCode[1:0]: 00 byte, 01 half, 11 word, 10 reserved.
- `LoadUnsigned`  in  1  1 = zero-extend sub-word load, 0 = sign-extend.
- `Addr`  in  ADDR_WIDTH  byte address (ALU result).
- `WriteData`  in  32  store data (rt); low byte/half used for SB/SH.
- `ReadData`  out  32  registered load result to MemToReg mux.
- `Busy`  out  1  high whenever FSM is not IDLE.
- `Done`  out  1  one-cycle completion pulse.
- `Error`  out  1  one-cycle pulse, coincident with `Done`, on a rejected request.
- `MemAddr`  out  ADDR_WIDTH-2  word address = `Addr[ADDR_WIDTH-1:2]`.
- `MemRdEn`  out  1  memory read strobe; data valid on `MemRData` one cycle later.
- `MemWrEn`  out  1  memory write strobe; full-word write of `MemWData`.
- `MemWData`  out  32  memory write data.
- `MemRData`  in  32  memory read data.

## Operation
- Byte order: big-endian. Byte offset 0 = bits [31:24]. Half offset 0 = bits [31:16].
- FSM states:
  - IDLE, READ, CAPTURE, WRITE, DONE.
- Acceptance in IDLE with `Start`=1. `Addr`, `Size`, `LoadUnsigned` and `WriteData` are latched.
- Rejection conditions, which lead to DONE with `Error`=1 and no memory strobe:
  - `Size`=10.
  - Half access with `Addr[0]`=1.
  - Word access with `Addr[1:0]`≠0.
  - `MemRead` and `MemWrite` both 1.
- `Start` with neither read nor write: go to DONE and pulse `Done` with no access. `Error`=0.
- Load path: IDLE→READ→CAPTURE→DONE→IDLE.
  - READ: `MemRdEn`=1 for one cycle.
  - CAPTURE: select lane from `MemRData`, extend to 32 bits, register into `ReadData`.
- Word store path: IDLE→WRITE→DONE→IDLE. `MemWData`=`WriteData`.
- Sub-word store path: IDLE→READ→CAPTURE→WRITE→DONE→IDLE.
  - CAPTURE merges the latched byte/half into the captured word at the addressed lane.
  - WRITE issues that merged word.
- DONE: `Done`=1 for one cycle, then unconditional return to IDLE.
- `ReadData` holds its value until the next successful load. Stores and rejections leave it unchanged.
- `Start` while `Busy` is ignored and is not queued.

## Timing
- Reset values: `ReadData`=0, `Busy`=0, `Done`=0, `Error`=0, `MemRdEn`=0, `MemWrEn`=0, `MemAddr`=0, `MemWData`=0, state IDLE.
- All outputs are registered.
- Latencies, with `Start` sampled at edge k:
  - Rejection or no-op: `Done` high in cycle k+1.
  - Word store: `Done` high in cycle k+2.
  - Load: `Done` high in cycle k+3.
  - Sub-word store: `Done` high in cycle k+4.
- `Busy` goes high the cycle after acceptance and low the cycle after DONE.
- Reset asserted mid-operation:
  - All outputs clear and state returns to IDLE immediately, with no clock edge needed.
  - A pending WRITE is abandoned, so `MemWrEn` drops and no partial write occurs.
- Back-to-back: a new `Start` sampled in the cycle after DONE is accepted. Maximum throughput is one request per latency+1 cycles.

## Configuration
- `MEM_BYTE_ENABLE_EN` defined:
  - Adds output `MemBe` (4 bits; bit 3 = byte lane 0).
  - Sub-word stores skip READ/CAPTURE and write directly. SB/SH latency becomes k+2.
  - `MemWData` replicates the byte or half across lanes.
  - Loads are unchanged.
  - Word stores drive `MemBe`=1111.
- `MEM_BYTE_ENABLE_EN` undefined: no `MemBe` port. Sub-word stores use read-modify-write as above.

## Test plan
- LW, `Addr`=0x10, memory word 4 = 0xDEADBEEF -> one `MemRdEn` pulse with `MemAddr`=4. `Done` at k+3. `ReadData`=0xDEADBEEF.
- LB, `Addr`=0x11, word = 0x12F45678 -> `ReadData`=0xFFFFFFF4 when signed. With `LoadUnsigned`=1 -> 0x000000F4.
- SB, `Addr`=0x13, `WriteData`=0x000000AA over 0x11223344 -> memory becomes 0x112233AA with `Done` at k+4. With `MEM_BYTE_ENABLE_EN`: k+2, `MemBe`=0001.
- SH, `Addr`=0x22, `WriteData`=0x0000BEEF over 0x11223344 -> memory becomes 0x1122BEEF. `ReadData` unchanged.
- LH, `Addr`=0x21 -> `Error`=1 and `Done`=1 at k+1. No `MemRdEn`/`MemWrEn` pulses.
- `Start` pulsed during a busy SB is ignored. `Rst` dropped while in WRITE -> `MemWrEn`=0 immediately, memory unchanged, `Busy`=0.
